// File: rtl/fetch_ctl_pkg.sv
// fetch_ctl_pkg
// Shared definitions for the fetch controller: FSM state encoding and the
// default mispredict-counter width.
package fetch_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_CNT_W = 16;

endpackage

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb
// Combinational priority resolver for the fetch stage. Given the controller
// state and the request inputs it decides whether the PC advances, which
// target (if any) is loaded, and which pipeline registers are squashed.
//
// Ports
//   i_state       current controller state
//   i_en          global step enable
//   i_stall       hazard stall from decode
//   i_wtg_req     execute-stage wrong-target redirect
//   i_bht_req     BHT taken prediction (already gated by build option)
//   i_halt        halt instruction decoded
//   o_pc_en       PC update enable
//   o_ld_wtg      load corrected target
//   o_ld_bht      load predicted target
//   o_flush_ifid  squash IF/ID
//   o_flush_idex  squash ID/EX
//   o_use_pend    corrected target comes from the pending register
//   o_halt_enter  halt accepted this cycle
import fetch_ctl_pkg::*;

module fetch_redirect_arb (
  input  fetch_state_e i_state,
  input  logic         i_en,
  input  logic         i_stall,
  input  logic         i_wtg_req,
  input  logic         i_bht_req,
  input  logic         i_halt,
  output logic         o_pc_en,
  output logic         o_ld_wtg,
  output logic         o_ld_bht,
  output logic         o_flush_ifid,
  output logic         o_flush_idex,
  output logic         o_use_pend,
  output logic         o_halt_enter
);

  always_comb begin
    o_pc_en      = 1'b0;
    o_ld_wtg     = 1'b0;
    o_ld_bht     = 1'b0;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    o_use_pend   = 1'b0;
    o_halt_enter = 1'b0;

    unique case (i_state)
      ST_RUN: begin
        if (i_en) begin
          if (i_wtg_req) begin
            // Redirect wins over stall, prediction and a (younger) halt.
            o_pc_en      = 1'b1;
            o_ld_wtg     = 1'b1;
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
          end else if (i_halt) begin
            o_flush_ifid = 1'b1;
            o_halt_enter = 1'b1;
          end else if (!i_stall) begin
            o_pc_en  = 1'b1;
            o_ld_bht = i_bht_req;
          end
        end
      end
      ST_PEND: begin
        if (i_en) begin
          o_pc_en      = 1'b1;
          o_ld_wtg     = 1'b1;
          o_flush_ifid = 1'b1;
          o_flush_idex = 1'b1;
          // A fresh redirect arriving now supersedes the latched one.
          o_use_pend   = !i_wtg_req;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctl.sv
// fetch_ctl
// Fetch controller: sequences the IF-stage PC (sequential / predicted /
// corrected target), runs the halt/resume FSM, holds a wrong-target redirect
// that arrives while the core is frozen, and counts applied mispredicts.
//
// Build option: define FETCH_CTL_BHT_EN to honour BHT predictions; otherwise
// i_bht_req/i_bht_pc are ignored and the BHT load outputs are tied low.
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_en                    global step enable (0 freezes state, except
//                           pending-redirect capture)
//   i_stall                 hazard stall
//   i_wtg_req, i_wtg_pc     execute-stage wrong-target redirect
//   i_bht_req, i_bht_pc     BHT taken prediction
//   i_halt, i_go            halt pulse / resume request
//   o_pc_en                 PC update enable
//   o_pc_ld_wtg/o_pc_ld_bht PC load selects (mutually exclusive)
//   o_wtg_pc_new/o_bht_pc_new  targets to the PC (0 when not loading)
//   o_flush_ifid/o_flush_idex  pipeline squashes
//   o_halted                FSM is in HALT
//   o_mispredict_cnt        applied wtg redirects, wraps
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetch
// PEND  | wtg redirect latched while frozen, applied on first en=1 cycle
// HALT  | halted; waits for go with en=1

// IM_ADDR_NBIT normally comes from Core.vh; fallback for standalone builds.
`ifndef IM_ADDR_NBIT
`define IM_ADDR_NBIT 32
`endif

import fetch_ctl_pkg::*;

module fetch_ctl #(
  parameter int unsigned AddrW = `IM_ADDR_NBIT,
  parameter int unsigned CntW  = FETCH_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_stall,
  input  logic             i_wtg_req,
  input  logic [AddrW-1:0] i_wtg_pc,
  input  logic             i_bht_req,
  input  logic [AddrW-1:0] i_bht_pc,
  input  logic             i_halt,
  input  logic             i_go,
  output logic             o_pc_en,
  output logic             o_pc_ld_wtg,
  output logic             o_pc_ld_bht,
  output logic [AddrW-1:0] o_wtg_pc_new,
  output logic [AddrW-1:0] o_bht_pc_new,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_halted,
  output logic [CntW-1:0]  o_mispredict_cnt
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [AddrW-1:0] r_pend_pc;
  logic [AddrW-1:0] w_pend_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;

  logic             w_bht_req;
  logic             w_pc_en;
  logic             w_ld_wtg;
  logic             w_ld_bht;
  logic             w_flush_ifid;
  logic             w_flush_idex;
  logic             w_use_pend;
  logic             w_halt_enter;
  logic [AddrW-1:0] w_wtg_target;

`ifdef FETCH_CTL_BHT_EN
  assign w_bht_req = i_bht_req;
`else
  logic w_unused_bht;
  assign w_bht_req    = 1'b0;
  assign w_unused_bht = ^{i_bht_req, i_bht_pc};
`endif

  fetch_redirect_arb u_arb (
    .i_state      (r_state),
    .i_en         (i_en),
    .i_stall      (i_stall),
    .i_wtg_req    (i_wtg_req),
    .i_bht_req    (w_bht_req),
    .i_halt       (i_halt),
    .o_pc_en      (w_pc_en),
    .o_ld_wtg     (w_ld_wtg),
    .o_ld_bht     (w_ld_bht),
    .o_flush_ifid (w_flush_ifid),
    .o_flush_idex (w_flush_idex),
    .o_use_pend   (w_use_pend),
    .o_halt_enter (w_halt_enter)
  );

  assign w_wtg_target = w_use_pend ? r_pend_pc : i_wtg_pc;

  // Every control output is held low for as long as reset is asserted,
  // independent of the (already reset) registers.
  assign o_pc_en          = i_rst_n & w_pc_en;
  assign o_pc_ld_wtg      = i_rst_n & w_ld_wtg;
  assign o_pc_ld_bht      = i_rst_n & w_ld_bht;
  assign o_flush_ifid     = i_rst_n & w_flush_ifid;
  assign o_flush_idex     = i_rst_n & w_flush_idex;
  assign o_halted         = i_rst_n & (r_state == ST_HALT);
  assign o_wtg_pc_new     = (i_rst_n && w_ld_wtg) ? w_wtg_target : '0;
  assign o_mispredict_cnt = r_cnt;
`ifdef FETCH_CTL_BHT_EN
  assign o_bht_pc_new     = (i_rst_n && w_ld_bht) ? i_bht_pc : '0;
`else
  assign o_bht_pc_new     = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_pc;
    w_cnt_nxt   = w_ld_wtg ? r_cnt + CntW'(1) : r_cnt;

    unique case (r_state)
      ST_RUN: begin
        if (i_en) begin
          if (w_halt_enter) w_state_nxt = ST_HALT;
        end else if (i_wtg_req) begin
          // Frozen core: remember the redirect instead of dropping it.
          w_state_nxt = ST_PEND;
          w_pend_nxt  = i_wtg_pc;
        end
      end
      ST_PEND: begin
        if (i_en) begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = '0;
        end else if (i_wtg_req) begin
          w_pend_nxt  = i_wtg_pc;
        end
      end
      ST_HALT: begin
        if (i_en && i_go) w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_RUN;
      r_pend_pc <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctl.sv
module tb_fetch_ctl;

  localparam int AW = 16;
  localparam int CW = 4;

`ifdef FETCH_CTL_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, stall, wtg_req, bht_req, halt, go;
  logic [AW-1:0] wtg_pc, bht_pc;
  logic          pc_en, pc_ld_wtg, pc_ld_bht, flush_ifid, flush_idex, halted;
  logic [AW-1:0] wtg_pc_new, bht_pc_new;
  logic [CW-1:0] mispredict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: abstract bookkeeping of what the controller must be doing.
  bit            m_halted;
  bit            m_pend;
  logic [AW-1:0] m_pend_pc;
  int            m_cnt;

  always #5 clk = ~clk;

  fetch_ctl #(.AddrW(AW), .CntW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_stall(stall),
    .i_wtg_req(wtg_req), .i_wtg_pc(wtg_pc), .i_bht_req(bht_req), .i_bht_pc(bht_pc),
    .i_halt(halt), .i_go(go),
    .o_pc_en(pc_en), .o_pc_ld_wtg(pc_ld_wtg), .o_pc_ld_bht(pc_ld_bht),
    .o_wtg_pc_new(wtg_pc_new), .o_bht_pc_new(bht_pc_new),
    .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex), .o_halted(halted),
    .o_mispredict_cnt(mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halted  = 1'b0;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_cnt     = 0;
  endtask

  task automatic check_all(input string tag);
    logic          e_pc_en, e_ld_w, e_ld_b, e_fi, e_fe, e_h;
    logic [AW-1:0] e_wn, e_bn;
    e_pc_en = 0; e_ld_w = 0; e_ld_b = 0; e_fi = 0; e_fe = 0; e_h = 0;
    e_wn = '0; e_bn = '0;
    if (!rst_n) model_reset();
    else if (m_halted) e_h = 1;
    else if (en && (m_pend || wtg_req)) begin
      e_pc_en = 1; e_ld_w = 1; e_fi = 1; e_fe = 1;
      e_wn = wtg_req ? wtg_pc : m_pend_pc;
    end else if (en && !m_pend) begin
      if (halt) e_fi = 1;
      else if (!stall) begin
        e_pc_en = 1;
        if (bht_req && BHT_ON) begin
          e_ld_b = 1;
          e_bn   = bht_pc;
        end
      end
    end
    chk({tag, ":pc_en"},      32'(pc_en),          32'(e_pc_en));
    chk({tag, ":pc_ld_wtg"},  32'(pc_ld_wtg),      32'(e_ld_w));
    chk({tag, ":pc_ld_bht"},  32'(pc_ld_bht),      32'(e_ld_b));
    chk({tag, ":wtg_pc_new"}, 32'(wtg_pc_new),     32'(e_wn));
    chk({tag, ":bht_pc_new"}, 32'(bht_pc_new),     32'(e_bn));
    chk({tag, ":flush_ifid"}, 32'(flush_ifid),     32'(e_fi));
    chk({tag, ":flush_idex"}, 32'(flush_idex),     32'(e_fe));
    chk({tag, ":halted"},     32'(halted),         32'(e_h));
    chk({tag, ":cnt"},        32'(mispredict_cnt), 32'(m_cnt % (1 << CW)));
  endtask

  task automatic model_clock();
    if (!rst_n) model_reset();
    else if (m_halted) begin
      if (en && go) m_halted = 0;
    end else if (en) begin
      if (m_pend || wtg_req) m_cnt++;
      else if (halt) m_halted = 1;
      m_pend = 0;
    end else if (wtg_req) begin
      m_pend    = 1;
      m_pend_pc = wtg_pc;
    end
  endtask

  // Check at mid-cycle, advance through the rising edge, end at the next falling edge.
  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1; stall = 0; wtg_req = 0; bht_req = 0; halt = 0; go = 0;
    wtg_pc = '0; bht_pc = '0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");

    // Come out of reset into normal sequential fetch.
    rst_n = 1;
    for (int i = 0; i < 4; i++) cyc("run");
    chk("run:cnt_after4", 32'(mispredict_cnt), 32'd0);
    chk("run:halted_after4", 32'(halted), 32'd0);
    #1 chk("run:pc_en_seq", 32'(pc_en), 32'd1);

    // Stall blocks a prediction; releasing it applies the prediction.
    stall = 1; bht_req = 1; bht_pc = 16'h0040;
    #1 chk("stall_bht:pc_en", 32'(pc_en), 32'd0);
    cyc("stall_bht");
    stall = 0;
    #1 chk("bht_rel:ld_bht", 32'(pc_ld_bht), 32'(BHT_ON));
    chk("bht_rel:bht_pc_new", 32'(bht_pc_new), BHT_ON ? 32'h40 : 32'h0);
    cyc("bht_rel");

    // Redirect beats stall and prediction.
    stall = 1; wtg_req = 1; wtg_pc = 16'h0080;
    #1 chk("wtg_pri:ld_wtg", 32'(pc_ld_wtg), 32'd1);
    chk("wtg_pri:ld_bht", 32'(pc_ld_bht), 32'd0);
    chk("wtg_pri:flush", 32'({flush_ifid, flush_idex}), 32'd3);
    cyc("wtg_pri");
    idle_inputs();
    chk("wtg_pri:cnt", 32'(mispredict_cnt), 32'd1);

    // Frozen redirects: last one wins and is applied once on re-enable.
    en = 0; wtg_req = 1; wtg_pc = 16'h0010;
    cyc("pend_a");
    wtg_pc = 16'h0020;
    cyc("pend_b");
    wtg_req = 0; wtg_pc = '0; en = 1;
    #1 chk("pend_apply:ld_wtg", 32'(pc_ld_wtg), 32'd1);
    chk("pend_apply:pc_new", 32'(wtg_pc_new), 32'h20);
    cyc("pend_apply");
    cyc("pend_after");
    chk("pend:cnt", 32'(mispredict_cnt), 32'd2);

    // Halt entry, ignored requests, resume.
    halt = 1;
    #1 chk("halt_in:flush_ifid", 32'(flush_ifid), 32'd1);
    cyc("halt_in");
    halt = 0; wtg_req = 1; bht_req = 1; wtg_pc = 16'h0123; bht_pc = 16'h0456;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halted:state", 32'(halted), 32'd1);
      chk("halted:flush_ifid", 32'(flush_ifid), 32'd0);
      cyc("halted");
    end
    wtg_req = 0; bht_req = 0; go = 1;
    cyc("go");
    go = 0;
    #1 chk("resumed:pc_en", 32'(pc_en), 32'd1);
    chk("resumed:halted", 32'(halted), 32'd0);
    chk("resumed:cnt", 32'(mispredict_cnt), 32'd2);
    cyc("resumed");

    // Reset asserted while a redirect is pending.
    en = 0; wtg_req = 1; wtg_pc = 16'h0055;
    cyc("pend_c");
    wtg_req = 0; en = 1;
    #2 rst_n = 0;
    #1 chk("rst_pend:pc_en", 32'(pc_en), 32'd0);
    chk("rst_pend:ld_wtg", 32'(pc_ld_wtg), 32'd0);
    chk("rst_pend:pc_new", 32'(wtg_pc_new), 32'd0);
    check_all("rst_pend");
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_rel:ld_wtg", 32'(pc_ld_wtg), 32'd0);
    chk("rst_rel:pc_en", 32'(pc_en), 32'd1);
    cyc("rst_rel");

    // Counter wrap.
    wtg_req = 1;
    for (int i = 0; i < (1 << CW); i++) begin
      wtg_pc = AW'($urandom);
      cyc("wrap");
    end
    chk("wrap:cnt0", 32'(mispredict_cnt), 32'd0);
    cyc("wrap1");
    chk("wrap:cnt1", 32'(mispredict_cnt), 32'd1);
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      wtg_req = ($urandom_range(0, 4) == 0);
      bht_req = ($urandom_range(0, 1) == 0);
      halt    = ($urandom_range(0, 7) == 0);
      go      = ($urandom_range(0, 3) == 0);
      wtg_pc  = AW'($urandom);
      bht_pc  = AW'($urandom);
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
